// File: rtl/tail_lights_blink_timer_if.sv
// Handshake bundle between the tail-light sequencing FSM and its interval timer.
//   clear_timer_dir / clear_timer_haz : FSM -> timer, restart/arm strobes
//   interr_dir      / interr_haz      : timer -> FSM, one-cycle end-of-interval pulses
// master = FSM side, slave = timer side.
interface tail_lights_blink_timer_if;
  logic clear_timer_dir;
  logic clear_timer_haz;
  logic interr_dir;
  logic interr_haz;

  modport master (
    output clear_timer_dir,
    output clear_timer_haz,
    input  interr_dir,
    input  interr_haz
  );

  modport slave (
    input  clear_timer_dir,
    input  clear_timer_haz,
    output interr_dir,
    output interr_haz
  );
endinterface

// File: rtl/tail_lights_blink_timer.sv
// Two-channel interval scheduler pacing the tail-light FSM.
// Each channel (direction, hazard) is armed/restarted by its clear strobe and
// emits a registered single-cycle pulse every PERIOD cycles thereafter.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : slave side of tail_lights_blink_timer_if
//           (clear_timer_dir/haz in, interr_dir/haz out)
module tail_lights_blink_timer #(
  parameter int unsigned DIR_PERIOD = 25_000_000,
  parameter int unsigned HAZ_PERIOD = 50_000_000
) (
  input  logic                         clk,
  input  logic                         reset,
  tail_lights_blink_timer_if.slave     bus
);

  localparam int unsigned DIR_W = $clog2(DIR_PERIOD);
  localparam int unsigned HAZ_W = $clog2(HAZ_PERIOD);

  localparam logic [DIR_W-1:0] DIR_LAST = DIR_W'(DIR_PERIOD - 1);
  localparam logic [HAZ_W-1:0] HAZ_LAST = HAZ_W'(HAZ_PERIOD - 1);
  localparam logic [DIR_W-1:0] DIR_ONE  = DIR_W'(1);
  localparam logic [HAZ_W-1:0] HAZ_ONE  = HAZ_W'(1);

  typedef enum logic {
    DISARMED = 1'b0,
    COUNTING = 1'b1
  } chan_state_e;

  chan_state_e      dir_state_q, dir_state_d;
  chan_state_e      haz_state_q, haz_state_d;
  logic [DIR_W-1:0] dir_cnt_q, dir_cnt_d;
  logic [HAZ_W-1:0] haz_cnt_q, haz_cnt_d;
  logic             dir_pulse_q, dir_pulse_d;
  logic             haz_pulse_q, haz_pulse_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dir_state_q <= DISARMED;
      haz_state_q <= DISARMED;
      dir_cnt_q   <= '0;
      haz_cnt_q   <= '0;
      dir_pulse_q <= 1'b0;
      haz_pulse_q <= 1'b0;
    end else begin
      dir_state_q <= dir_state_d;
      haz_state_q <= haz_state_d;
      dir_cnt_q   <= dir_cnt_d;
      haz_cnt_q   <= haz_cnt_d;
      dir_pulse_q <= dir_pulse_d;
      haz_pulse_q <= haz_pulse_d;
    end
  end

  // Direction channel. Clear outranks terminal count, so a restart landing on
  // the terminal edge suppresses that pulse. Pulse defaults low every cycle,
  // which bounds it to a single cycle.
  always_comb begin
    dir_state_d = dir_state_q;
    dir_cnt_d   = '0;
    dir_pulse_d = 1'b0;
    unique case (dir_state_q)
      DISARMED: begin
        if (bus.clear_timer_dir) dir_state_d = COUNTING;
      end
      COUNTING: begin
        if (bus.clear_timer_dir) begin
          dir_cnt_d = '0;
        end else if (dir_cnt_q == DIR_LAST) begin
          dir_cnt_d   = '0;
          dir_pulse_d = 1'b1;
        end else begin
          dir_cnt_d = dir_cnt_q + DIR_ONE;
        end
      end
    endcase
  end

  // Hazard channel: same structure, independent state.
  always_comb begin
    haz_state_d = haz_state_q;
    haz_cnt_d   = '0;
    haz_pulse_d = 1'b0;
    unique case (haz_state_q)
      DISARMED: begin
        if (bus.clear_timer_haz) haz_state_d = COUNTING;
      end
      COUNTING: begin
        if (bus.clear_timer_haz) begin
          haz_cnt_d = '0;
        end else if (haz_cnt_q == HAZ_LAST) begin
          haz_cnt_d   = '0;
          haz_pulse_d = 1'b1;
        end else begin
          haz_cnt_d = haz_cnt_q + HAZ_ONE;
        end
      end
    endcase
  end

  assign bus.interr_dir = dir_pulse_q;
  assign bus.interr_haz = haz_pulse_q;

endmodule

// File: tb/tb_tail_lights_blink_timer.sv
// Directed bench for tail_lights_blink_timer with DIR_PERIOD=5, HAZ_PERIOD=8.
// Inputs are driven and outputs sampled 1 time unit after each rising edge;
// "k" counts edges since the arming edge E0.
module tb_tail_lights_blink_timer;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  tail_lights_blink_timer_if bus ();

  tail_lights_blink_timer #(
    .DIR_PERIOD (5),
    .HAZ_PERIOD (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.clear_timer_dir = 1'b0;
    bus.clear_timer_haz = 1'b0;

    // Reset state.
    step();
    step();
    chk("rst_dir", bus.interr_dir, 1'b0);
    chk("rst_haz", bus.interr_haz, 1'b0);
    reset = 1'b0;

    // Disarmed after reset: no pulses without a clear.
    for (int k = 1; k <= 40; k++) begin
      step();
      chk($sformatf("disarm_dir k=%0d", k), bus.interr_dir, 1'b0);
      chk($sformatf("disarm_haz k=%0d", k), bus.interr_haz, 1'b0);
    end

    // Single-cycle arm of dir: pulses after E0+5, E0+10, E0+15.
    bus.clear_timer_dir = 1'b1;
    step();
    bus.clear_timer_dir = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step();
      chk($sformatf("arm_dir k=%0d", k), bus.interr_dir, (k % 5) == 0);
      chk($sformatf("arm_dir_haz k=%0d", k), bus.interr_haz, 1'b0);
    end

    // Held clear: no pulses; release at E0 (last held edge).
    bus.clear_timer_dir = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      chk($sformatf("hold_dir k=%0d", k), bus.interr_dir, 1'b0);
    end
    bus.clear_timer_dir = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      step();
      chk($sformatf("release_dir k=%0d", k), bus.interr_dir, (k % 5) == 0);
    end

    // Hazard restart on its terminal-count edge (E0+7): no pulse at E0+8,
    // next at E0+15. Dir is held cleared and must stay quiet.
    bus.clear_timer_dir = 1'b1;
    bus.clear_timer_haz = 1'b1;
    step();
    bus.clear_timer_haz = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      bus.clear_timer_haz = (k == 7);
      step();
      chk($sformatf("haz_tc k=%0d", k), bus.interr_haz, k == 15);
      chk($sformatf("haz_tc_dir k=%0d", k), bus.interr_dir, 1'b0);
    end
    bus.clear_timer_haz = 1'b0;

    // Both armed on the same edge: coincident pulses at E0+40.
    bus.clear_timer_dir = 1'b1;
    bus.clear_timer_haz = 1'b1;
    step();
    bus.clear_timer_dir = 1'b0;
    bus.clear_timer_haz = 1'b0;
    for (int k = 1; k <= 41; k++) begin
      step();
      chk($sformatf("both_dir k=%0d", k), bus.interr_dir, (k % 5) == 0);
      chk($sformatf("both_haz k=%0d", k), bus.interr_haz, (k % 8) == 0);
    end

    // Async reset with dir at cnt=3.
    bus.clear_timer_dir = 1'b1;
    step();
    bus.clear_timer_dir = 1'b0;
    step();
    step();
    step();
    reset = 1'b1;
    #2;
    chk("async_rst_dir", bus.interr_dir, 1'b0);
    chk("async_rst_haz", bus.interr_haz, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      step();
      chk($sformatf("in_rst_dir k=%0d", k), bus.interr_dir, 1'b0);
      chk($sformatf("in_rst_haz k=%0d", k), bus.interr_haz, 1'b0);
    end
    reset = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      chk($sformatf("post_rst_dir k=%0d", k), bus.interr_dir, 1'b0);
      chk($sformatf("post_rst_haz k=%0d", k), bus.interr_haz, 1'b0);
    end
    bus.clear_timer_dir = 1'b1;
    step();
    bus.clear_timer_dir = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk($sformatf("rearm_dir k=%0d", k), bus.interr_dir, k == 5);
      chk($sformatf("rearm_haz k=%0d", k), bus.interr_haz, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
